fc_rx_framer: RTL and testbench

FC_RX_FRAMER -- requirements
Module: fc_rx_framer

---
 rtl/fc_rx_framer.sv | 155 +++++++++++++++
 tb/tb_fc_rx_framer.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/fc_rx_framer.sv
// Fibre Channel receive framer: delimits frames on SOF/EOF ordered sets and emits Avalon-ST beats.
// Optional statistics counters are built only when FC_RX_FRAMER_STATS_EN is defined.
module fc_rx_framer #(
   parameter int MAX_WORDS = 539
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic [35:0] in_data,
   input  logic        in_valid,
   output logic [31:0] out_data,
   output logic        out_valid,
   output logic        out_sop,
   output logic        out_eop,
   output logic        out_error,
   output logic [31:0] frames_ok,
   output logic [31:0] frames_err
);

   // state   | meaning
   // IDLE    | waiting for a valid SOF, nothing emitted
   // FRAME   | inside a frame, every input cycle produces one beat
   // DISCARD | frame truncated at MAX_WORDS, dropping words until EOF or link loss
   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      FRAME   = 2'd1,
      DISCARD = 2'd2
   } state_t;

   localparam logic [9:0] MAX_CNT = 10'(MAX_WORDS);

   state_t      state, state_nxt;
   logic [9:0]  word_cnt, word_cnt_nxt;
   logic [31:0] data_nxt;
   logic        valid_nxt, sop_nxt, eop_nxt, error_nxt;

   logic [3:0]  datak;
   logic [31:0] word;
   logic        k_lead, byte_rep, sof_code, eof_code;
   logic        is_sof, is_eof, is_eof_abort, is_data;

   assign datak = in_data[35:32];
   assign word  = in_data[31:0];

   assign k_lead   = (datak == 4'b1000);
   assign byte_rep = (word[15:8] == word[7:0]);

   always_comb begin
      sof_code = 1'b0;
      case (word[7:0])
         8'h17, 8'h57, 8'h37, 8'h55, 8'h35, 8'h56, 8'h36, 8'h58: sof_code = 1'b1;
         default: sof_code = 1'b0;
      endcase
   end

   assign eof_code = (word[7:0] == 8'h75) || (word[7:0] == 8'hD5) || (word[7:0] == 8'hF5);

   assign is_sof = k_lead && (word[31:16] == 16'hBCB5) && byte_rep && sof_code;
   assign is_eof = k_lead && (word[31:24] == 8'hBC) &&
                   ((word[23:16] == 8'h95) || (word[23:16] == 8'hB5)) &&
                   byte_rep && eof_code;
   assign is_eof_abort = (word[7:0] == 8'hF5);
   assign is_data      = (datak == 4'b0000);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state     <= IDLE;
         word_cnt  <= '0;
         out_data  <= '0;
         out_valid <= 1'b0;
         out_sop   <= 1'b0;
         out_eop   <= 1'b0;
         out_error <= 1'b0;
      end else begin
         state     <= state_nxt;
         word_cnt  <= word_cnt_nxt;
         out_data  <= data_nxt;
         out_valid <= valid_nxt;
         out_sop   <= sop_nxt;
         out_eop   <= eop_nxt;
         out_error <= error_nxt;
      end
   end

   // word_cnt holds the number of beats already emitted for the current frame
   always_comb begin
      state_nxt    = state;
      word_cnt_nxt = word_cnt;
      data_nxt     = '0;
      valid_nxt    = 1'b0;
      sop_nxt      = 1'b0;
      eop_nxt      = 1'b0;
      error_nxt    = 1'b0;
      case (state)
         IDLE: begin
            if (in_valid && is_sof) begin
               valid_nxt    = 1'b1;
               sop_nxt      = 1'b1;
               data_nxt     = word;
               word_cnt_nxt = 10'd1;
               state_nxt    = FRAME;
            end
         end
         FRAME: begin
            valid_nxt = 1'b1;
            if (!in_valid) begin
               eop_nxt   = 1'b1;
               error_nxt = 1'b1;
               state_nxt = IDLE;
            end else if (is_eof) begin
               data_nxt  = word;
               eop_nxt   = 1'b1;
               error_nxt = is_eof_abort;
               state_nxt = IDLE;
            end else if (is_data) begin
               data_nxt = word;
               if (word_cnt == MAX_CNT - 10'd1) begin
                  eop_nxt   = 1'b1;
                  error_nxt = 1'b1;
                  state_nxt = DISCARD;
               end else begin
                  word_cnt_nxt = word_cnt + 10'd1;
               end
            end else begin
               data_nxt  = word;
               eop_nxt   = 1'b1;
               error_nxt = 1'b1;
               state_nxt = IDLE;
            end
         end
         DISCARD: begin
            if (!in_valid || is_eof) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

`ifdef FC_RX_FRAMER_STATS_EN
   // Counters advance on the same edge that registers the eop beat.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         frames_ok  <= '0;
         frames_err <= '0;
      end else begin
         if (eop_nxt && !error_nxt && (frames_ok != 32'hFFFF_FFFF))
            frames_ok <= frames_ok + 32'd1;
         if (eop_nxt && error_nxt && (frames_err != 32'hFFFF_FFFF))
            frames_err <= frames_err + 32'd1;
      end
   end
`else
   assign frames_ok  = '0;
   assign frames_err = '0;
`endif

endmodule

// File: tb/tb_fc_rx_framer.sv
// Directed self-checking bench for fc_rx_framer; beat expectations hand-computed per input word.
module tb_fc_rx_framer;

   logic        clk;
   logic        reset_n;
   logic [35:0] in_data;
   logic        in_valid;
   logic [31:0] out_data;
   logic        out_valid, out_sop, out_eop, out_error;
   logic [31:0] frames_ok, frames_err;

   int n_assert = 0;
   int n_fail   = 0;
   int exp_ok   = 0;
   int exp_err  = 0;
   int n_beats  = 0;

   localparam logic [35:0] NONE = 36'h0;
   localparam logic [3:0]  K    = 4'b1000;
   localparam logic [3:0]  D    = 4'b0000;

   fc_rx_framer #(.MAX_WORDS(539)) dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .in_data    (in_data),
      .in_valid   (in_valid),
      .out_data   (out_data),
      .out_valid  (out_valid),
      .out_sop    (out_sop),
      .out_eop    (out_eop),
      .out_error  (out_error),
      .frames_ok  (frames_ok),
      .frames_err (frames_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [35:0] beat(input logic sop, input logic eop, input logic err,
                                        input logic [31:0] d);
      return {1'b1, sop, eop, err, d};
   endfunction

   task automatic chk_beat(input string tag, input logic [35:0] exp);
      logic [35:0] obs;
      obs = {out_valid, out_sop, out_eop, out_error, out_data};
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed {v,sop,eop,err,data}=%h expected %h", tag, obs, exp);
      end
   endtask

   task automatic chk_stats(input string tag);
      logic [63:0] obs, exp;
      obs = {frames_ok, frames_err};
`ifdef FC_RX_FRAMER_STATS_EN
      exp = {32'(exp_ok), 32'(exp_err)};
`else
      exp = 64'h0;
`endif
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed ok/err=%h expected %h", tag, obs, exp);
      end
   endtask

   // Present one word for one cycle, then check the beat it produced.
   task automatic step(input string tag, input logic v, input logic [3:0] k,
                       input logic [31:0] w, input logic [35:0] exp);
      in_valid = v;
      in_data  = {k, w};
      @(posedge clk);
      #1;
      chk_beat(tag, exp);
      if (exp[35] === 1'b1) n_beats++;
   endtask

   initial begin
      reset_n  = 1'b0;
      in_valid = 1'b0;
      in_data  = '0;
      #12;
      chk_beat("reset_outputs", NONE);
      chk_stats("reset_stats");
      @(negedge clk);
      reset_n = 1'b1;
      @(posedge clk);
      #1;

      // Idles, then a clean frame
      step("idle0", 1, K, 32'hBC95_0000, NONE);
      step("idle1", 1, K, 32'hBC95_0000, NONE);
      step("sof_bad_code", 1, K, 32'hBCB5_1818, NONE);
      step("sof_bad_rep",  1, K, 32'hBCB5_3736, NONE);
      step("data_in_idle", 1, D, 32'h1234_5678, NONE);
      step("f1_sof", 1, K, 32'hBCB5_3737, beat(1, 0, 0, 32'hBCB5_3737));
      step("f1_d1",  1, D, 32'h1111_1111, beat(0, 0, 0, 32'h1111_1111));
      step("f1_d2",  1, D, 32'h2222_2222, beat(0, 0, 0, 32'h2222_2222));
      step("f1_d3",  1, D, 32'h3333_3333, beat(0, 0, 0, 32'h3333_3333));
      step("f1_eof", 1, K, 32'hBC95_7575, beat(0, 1, 0, 32'hBC95_7575));
      exp_ok++;
      chk_stats("f1_stats");
      step("f1_after", 1, K, 32'hBC95_0000, NONE);

      // Abort delimiter
      step("f2_sof", 1, K, 32'hBCB5_5656, beat(1, 0, 0, 32'hBCB5_5656));
      step("f2_d1",  1, D, 32'hA5A5_0001, beat(0, 0, 0, 32'hA5A5_0001));
      step("f2_d2",  1, D, 32'hA5A5_0002, beat(0, 0, 0, 32'hA5A5_0002));
      step("f2_eofa", 1, K, 32'hBC95_F5F5, beat(0, 1, 1, 32'hBC95_F5F5));
      exp_err++;
      chk_stats("f2_stats");

      // Link loss mid-frame, then clean restart with EOFn (B5 variant)
      step("f3_sof", 1, K, 32'hBCB5_1717, beat(1, 0, 0, 32'hBCB5_1717));
      step("f3_d1",  1, D, 32'hCAFE_0001, beat(0, 0, 0, 32'hCAFE_0001));
      step("f3_lost", 0, D, 32'hDEAD_BEEF, beat(0, 1, 1, 32'h0));
      exp_err++;
      step("f3_lost2", 0, D, 32'hDEAD_BEEF, NONE);
      step("f3_data_idle", 1, D, 32'hCAFE_0002, NONE);
      step("f4_sof", 1, K, 32'hBCB5_5555, beat(1, 0, 0, 32'hBCB5_5555));
      step("f4_d1",  1, D, 32'hCAFE_0003, beat(0, 0, 0, 32'hCAFE_0003));
      step("f4_eofn", 1, K, 32'hBCB5_D5D5, beat(0, 1, 0, 32'hBCB5_D5D5));
      exp_ok++;
      chk_stats("f4_stats");

      // Second SOF inside a frame
      step("f5_sof",  1, K, 32'hBCB5_5858, beat(1, 0, 0, 32'hBCB5_5858));
      step("f5_d1",   1, D, 32'h0505_0001, beat(0, 0, 0, 32'h0505_0001));
      step("f5_sof2", 1, K, 32'hBCB5_3535, beat(0, 1, 1, 32'hBCB5_3535));
      exp_err++;
      step("f5_drop1", 1, D, 32'h0505_0002, NONE);
      step("f5_drop2", 1, D, 32'h0505_0003, NONE);
      step("f5_drop_eof", 1, K, 32'hBC95_7575, NONE);

      // Other K character inside a frame
      step("f6_sof", 1, K, 32'hBCB5_3636, beat(1, 0, 0, 32'hBCB5_3636));
      step("f6_k",   1, K, 32'hBC95_0000, beat(0, 1, 1, 32'hBC95_0000));
      exp_err++;
      chk_stats("f6_stats");

      // Oversize frame: 539th beat truncates, remainder discarded until EOF
      n_beats = 0;
      step("f7_sof", 1, K, 32'hBCB5_5757, beat(1, 0, 0, 32'hBCB5_5757));
      for (int i = 1; i <= 600; i++) begin
         if (i < 538)
            step("f7_data", 1, D, 32'(i), beat(0, 0, 0, 32'(i)));
         else if (i == 538)
            step("f7_trunc", 1, D, 32'(i), beat(0, 1, 1, 32'(i)));
         else
            step("f7_discard", 1, D, 32'(i), NONE);
      end
      exp_err++;
      step("f7_eof", 1, K, 32'hBC95_7575, NONE);
      n_assert++;
      assert (n_beats == 539) else begin
         n_fail++;
         $error("FAIL f7_beat_count: observed %0d expected 539", n_beats);
      end
      chk_stats("f7_stats");
      step("f8_sof", 1, K, 32'hBCB5_3737, beat(1, 0, 0, 32'hBCB5_3737));
      step("f8_eof", 1, K, 32'hBC95_7575, beat(0, 1, 0, 32'hBC95_7575));
      exp_ok++;
      chk_stats("f8_stats");

      // Reset mid-frame
      step("f9_sof", 1, K, 32'hBCB5_3737, beat(1, 0, 0, 32'hBCB5_3737));
      step("f9_d1",  1, D, 32'h9999_0001, beat(0, 0, 0, 32'h9999_0001));
      reset_n = 1'b0;
      #1;
      chk_beat("f9_reset_async", NONE);
      exp_ok  = 0;
      exp_err = 0;
      chk_stats("f9_reset_stats");
      @(negedge clk);
      reset_n = 1'b1;
      step("f9_post_data", 1, D, 32'h9999_0002, NONE);
      step("f9_post_eof",  1, K, 32'hBC95_7575, NONE);
      step("f10_sof", 1, K, 32'hBCB5_3535, beat(1, 0, 0, 32'hBCB5_3535));
      step("f10_d1",  1, D, 32'h7777_0001, beat(0, 0, 0, 32'h7777_0001));
      step("f10_eof", 1, K, 32'hBCB5_7575, beat(0, 1, 0, 32'hBCB5_7575));
      exp_ok++;
      chk_stats("f10_stats");

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
